// File: rtl/id_stage_if.sv
// Fetch-to-decode channel: one instruction and its PC offered with valid/ready.
interface id_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           instr_i;
    logic [DATA_WIDTH-1:0] pc_i;
    logic                  instr_valid_i;
    logic                  instr_ready_o;

    modport master (
        output instr_i,
        output pc_i,
        output instr_valid_i,
        input  instr_ready_o
    );

    modport slave (
        input  instr_i,
        input  pc_i,
        input  instr_valid_i,
        output instr_ready_o
    );
endinterface

// File: rtl/id_stage.sv
// rv32i decode stage: decodes one instruction per handshake into ALU opcode,
// operands and writeback control, held in a single valid/ready pipeline register.
`ifndef OP_ALU_ADD
`define OP_ALU_ADD  6'd0
`define OP_ALU_SUB  6'd1
`define OP_ALU_SLL  6'd2
`define OP_ALU_SLT  6'd3
`define OP_ALU_SLTU 6'd4
`define OP_ALU_XOR  6'd5
`define OP_ALU_SRL  6'd6
`define OP_ALU_SRA  6'd7
`define OP_ALU_OR   6'd8
`define OP_ALU_AND  6'd9
`endif

module id_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    id_stage_if.slave             fetch,
    output logic [4:0]            rs1_addr_o,
    output logic [4:0]            rs2_addr_o,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  logic                  flush_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [5:0]            alu_op_o,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic [DATA_WIDTH-1:0] b_o,
    output logic [DATA_WIDTH-1:0] store_data_o,
    output logic [4:0]            rd_addr_o,
    output logic                  rd_we_o,
    output logic                  is_load_o,
    output logic                  is_store_o,
    output logic                  illegal_o
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    function automatic logic [5:0] f3_alu_op(input logic [2:0] f3);
        case (f3)
            3'b000:  f3_alu_op = `OP_ALU_ADD;
            3'b001:  f3_alu_op = `OP_ALU_SLL;
            3'b010:  f3_alu_op = `OP_ALU_SLT;
            3'b011:  f3_alu_op = `OP_ALU_SLTU;
            3'b100:  f3_alu_op = `OP_ALU_XOR;
            3'b101:  f3_alu_op = `OP_ALU_SRL;
            3'b110:  f3_alu_op = `OP_ALU_OR;
            default: f3_alu_op = `OP_ALU_AND;
        endcase
    endfunction

    logic [31:0]           w_instr;
    logic [6:0]            w_opcode;
    logic [2:0]            w_f3;
    logic [6:0]            w_f7;
    logic [4:0]            w_rd;
    logic [DATA_WIDTH-1:0] w_imm_i;
    logic [DATA_WIDTH-1:0] w_imm_s;
    logic [DATA_WIDTH-1:0] w_imm_u;
    logic                  w_capture;

    logic [5:0]            w_alu_op;
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic [DATA_WIDTH-1:0] w_store_data;
    logic                  w_writes_rd;
    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_illegal;

    logic                  r_valid;
    logic [5:0]            r_alu_op;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_store_data;
    logic [4:0]            r_rd_addr;
    logic                  r_rd_we;
    logic                  r_is_load;
    logic                  r_is_store;
    logic                  r_illegal;

    assign w_instr  = fetch.instr_i;
    assign w_opcode = w_instr[6:0];
    assign w_f3     = w_instr[14:12];
    assign w_f7     = w_instr[31:25];
    assign w_rd     = w_instr[11:7];
    assign w_imm_i  = DATA_WIDTH'($signed(w_instr[31:20]));
    assign w_imm_s  = DATA_WIDTH'($signed({w_instr[31:25], w_instr[11:7]}));
    assign w_imm_u  = DATA_WIDTH'($signed({w_instr[31:12], 12'b0}));

    assign rs1_addr_o          = w_instr[19:15];
    assign rs2_addr_o          = w_instr[24:20];
    assign fetch.instr_ready_o = !r_valid || ready_i;
    assign w_capture           = fetch.instr_valid_i && fetch.instr_ready_o;

    always_comb begin
        w_alu_op     = `OP_ALU_ADD;
        w_a          = '0;
        w_b          = '0;
        w_store_data = '0;
        w_writes_rd  = 1'b0;
        w_is_load    = 1'b0;
        w_is_store   = 1'b0;
        w_illegal    = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_a         = rs1_data_i;
                w_b         = rs2_data_i;
                w_writes_rd = 1'b1;
                if (w_f7 == F7_ZERO)                       w_alu_op = f3_alu_op(w_f3);
                else if (w_f7 == F7_ALT && w_f3 == 3'b000) w_alu_op = `OP_ALU_SUB;
                else if (w_f7 == F7_ALT && w_f3 == 3'b101) w_alu_op = `OP_ALU_SRA;
                else                                       w_illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                w_a         = rs1_data_i;
                w_b         = w_imm_i;
                w_writes_rd = 1'b1;
                w_alu_op    = f3_alu_op(w_f3);
                // Shift-immediates reuse the upper I-imm bits as funct7.
                if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
                    w_b = DATA_WIDTH'(w_instr[24:20]);
                    if (w_f7 == F7_ZERO)                       w_alu_op = f3_alu_op(w_f3);
                    else if (w_f7 == F7_ALT && w_f3 == 3'b101) w_alu_op = `OP_ALU_SRA;
                    else                                       w_illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                w_b         = w_imm_u;
                w_writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                w_a         = fetch.pc_i;
                w_b         = w_imm_u;
                w_writes_rd = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                w_a         = fetch.pc_i;
                w_b         = DATA_WIDTH'(4);
                w_writes_rd = 1'b1;
                if (w_opcode == OPC_JALR && w_f3 != 3'b000) w_illegal = 1'b1;
            end
            OPC_LOAD: begin
                w_a         = rs1_data_i;
                w_b         = w_imm_i;
                w_writes_rd = 1'b1;
                w_is_load   = 1'b1;
                if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111) w_illegal = 1'b1;
            end
            OPC_STORE: begin
                w_a          = rs1_data_i;
                w_b          = w_imm_s;
                w_store_data = rs2_data_i;
                w_is_store   = 1'b1;
                if (w_f3[2] || w_f3 == 3'b011) w_illegal = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
        // Illegal instructions collapse to a harmless ADD 0,0 with no side effects.
        if (w_illegal) begin
            w_alu_op     = `OP_ALU_ADD;
            w_a          = '0;
            w_b          = '0;
            w_store_data = '0;
            w_writes_rd  = 1'b0;
            w_is_load    = 1'b0;
            w_is_store   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_alu_op     <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_store_data <= '0;
            r_rd_addr    <= '0;
            r_rd_we      <= 1'b0;
            r_is_load    <= 1'b0;
            r_is_store   <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            if (flush_i)        r_valid <= 1'b0;
            else if (w_capture) r_valid <= 1'b1;
            else if (ready_i)   r_valid <= 1'b0;

            if (w_capture) begin
                r_alu_op     <= w_alu_op;
                r_a          <= w_a;
                r_b          <= w_b;
                r_store_data <= w_store_data;
                r_rd_addr    <= w_writes_rd ? w_rd : 5'd0;
                r_rd_we      <= w_writes_rd && (w_rd != 5'd0);
                r_is_load    <= w_is_load;
                r_is_store   <= w_is_store;
                r_illegal    <= w_illegal;
            end
        end
    end

    assign valid_o      = r_valid;
    assign alu_op_o     = r_alu_op;
    assign a_o          = r_a;
    assign b_o          = r_b;
    assign store_data_o = r_store_data;
    assign rd_addr_o    = r_rd_addr;
    assign rd_we_o      = r_rd_we;
    assign is_load_o    = r_is_load;
    assign is_store_o   = r_is_store;
    assign illegal_o    = r_illegal;

endmodule

// File: doc/id_stage.md
# id_stage

Decode stage of the rv32i core that sits directly upstream of `alu`. It takes one fetched instruction per handshake, reads source operands from the register file and generates immediates. It then registers the ALU opcode and the two ALU operands (`alu_op_i`, `a_i`, `b_i` of `alu`) plus writeback control for the execute stage. It is a single pipeline register with valid/ready flow control, a flush input and illegal-instruction flagging.

## Interface
- `DATA_WIDTH`, 32 (from `pkg_config`): operand/PC width.
- `clk`  in  1  core clock, all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `instr_i`  in  32  fetched instruction.
- `pc_i`  in  DATA_WIDTH  PC of `instr_i`.
- `instr_valid_i`  in  1  fetch offers `instr_i`/`pc_i`.
- `instr_ready_o`  out  1  stage accepts this cycle.
- `rs1_addr_o`, `rs2_addr_o`  out  5  combinational, `instr_i[19:15]` / `instr_i[24:20]`, to regfile read ports.
- `rs1_data_i`, `rs2_data_i`  in  DATA_WIDTH  regfile read data, combinational and same cycle.
- `flush_i`  in  1  kill the held and incoming instruction.
- `valid_o`  out  1  registered outputs hold a decoded instruction.
- `ready_i`  in  1  execute stage consumes this cycle.
- `alu_op_o`  out  6  ALU opcode, one of the `` `OP_ALU_* `` macros.
- `a_o`, `b_o`  out  DATA_WIDTH  ALU operands.
- `store_data_o`  out  DATA_WIDTH  `rs2_data_i` captured for STORE, else 0.
- `rd_addr_o`  out  5  destination register.
- `rd_we_o`  out  1  writeback enable.
- `is_load_o`, `is_store_o`  out  1  memory class of the instruction.
- `illegal_o`  out  1  instruction not decodable.

## Operation
- Decode by opcode `instr_i[6:0]`:
  - OP (0110011): a=rs1, b=rs2. funct3 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND. funct7=0100000 is legal only with funct3 000 (SUB) or 101 (SRA). Any other funct7 ≠ 0000000 is illegal.
  - OP-IMM (0010011): a=rs1, b=sign-extended I-imm.
    - SLLI/SRLI/SRAI: b = zero-extended `instr_i[24:20]`. funct7 must be 0000000, or 0100000 for SRAI only, else illegal.
  - LUI (0110111): a=0, b=U-imm (`instr_i[31:12]`,12'b0), ADD.
  - AUIPC (0010111): a=pc_i, b=U-imm, ADD.
  - JAL (1101111) / JALR (1100111, funct3 must be 000): a=pc_i, b=4, ADD (link value).
  - LOAD (0000011, funct3 ∈ {000,001,010,100,101}): a=rs1, b=I-imm, ADD, `is_load_o`=1.
  - STORE (0100011, funct3 ∈ {000,001,010}): a=rs1, b=S-imm, ADD, `is_store_o`=1, `rd_we_o`=0, `store_data_o`=rs2.
  - Any other opcode or funct combination: `illegal_o`=1, ADD with a=b=0, `rd_we_o`=0, load/store flags 0.
- `rd_addr_o` = `instr_i[11:7]` for rd-writing classes, else 0.
- `rd_we_o` is forced 0 when rd = x0.
- Immediates are sign-extended from bit 31. All arithmetic is DATA_WIDTH-wide with no truncation issues.
- Flow control:
  - `instr_ready_o = !valid_o || ready_i` (combinational).
  - Capture when `instr_valid_i && instr_ready_o`. All decoded fields load and `valid_o` is set to 1.
  - With no capture and `ready_i`=1, `valid_o` drops to 0. Data fields hold their last value.
  - With `valid_o`=1 and `ready_i`=0, all outputs hold stable.
- Flush: `flush_i`=1 sets `valid_o` to 0 next cycle and overrides a simultaneous capture. Data fields may update but are don't-care.
- Reset, `rst_n`=0 at an edge:
  - Every registered output goes to 0, including `valid_o`, `alu_op_o`, `a_o`, `b_o`, `store_data_o`, `rd_addr_o`, `rd_we_o`, the load/store flags and `illegal_o`.
  - Reset overrides flush and capture. Any in-flight instruction is discarded.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N with `valid_o`=1.
- Throughput is 1 instruction per cycle while `ready_i`=1. There are no bubbles between back-to-back accepts.
- `rs*_addr_o` → `rs*_data_i` is a same-cycle combinational path. The stage does no forwarding and no hazard detection.
- `instr_ready_o` depends only on `valid_o` and `ready_i`. It has no path from `instr_valid_i`.

## Test plan
- **ADDI x1,x2,-1.** Stimulus: `instr_i`=0xFFF10093, rs1_data=0x0000_0005. Response, next cycle: `valid_o`=1, ADD, a=0x0000_0005, b=0xFFFF_FFFF, rd=1, we=1, illegal=0.
- **SUB x3,x1,x2 and SRAI x1,x1,4.**
  - 0x402081B3 → SUB, a=rs1, b=rs2, rd=3.
  - 0x4040D093 → SRA, b=0x0000_0004.
  - Send back-to-back with `ready_i`=1: two consecutive valid cycles.
- **LUI and AUIPC.**
  - 0x123452B7 → ADD, a=0, b=0x1234_5000, rd=5.
  - AUIPC with pc_i=0x100 → a=0x100.
- **Illegal instruction.** 0x0000_0000, and also 0x02208033 (funct7=0000001) → `illegal_o`=1, `rd_we_o`=0, a=b=0.
- **Backpressure.** Hold `ready_i`=0 with `valid_o`=1 → `instr_ready_o`=0 and outputs stable for 3 cycles. Then raise `ready_i` → new instruction captured on that edge.
- **Flush and reset.**
  - `flush_i`=1 together with a capture → `valid_o`=0 next cycle.
  - `rst_n`=0 mid-stream → all outputs 0 after the edge and `instr_ready_o`=1.
